// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush scheduler: merges stall and redirect sources into one hold
// bus and one PC redirect, stretches post-redirect flushes and defers interrupts past divides.
module pipe_hold_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        div_busy_i,
    input  logic        rib_hold_i,
    input  logic        clint_hold_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        stall_timeout_o
);

    localparam logic [2:0]  HOLD_NONE  = 3'd0;
    localparam logic [2:0]  HOLD_PC    = 3'd1;
    localparam logic [2:0]  HOLD_ID    = 3'd3;
    localparam logic [1:0]  FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam logic [15:0] TO_LAST    = 16'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_flush_cnt;
    logic [1:0]  w_flush_cnt_nxt;
    logic        r_int_pend;
    logic [31:0] r_int_vec;
    logic [15:0] r_to_cnt;
    logic        r_to_flag;
    logic        w_redirect;
    logic [31:0] w_redirect_addr;
    logic        w_int_take;
    logic [2:0]  w_hold;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_redirect      = 1'b0;
        w_redirect_addr = '0;
        w_int_take      = 1'b0;
        case (r_state)
            S_RUN: begin
                // A pending interrupt outranks the ex jump; clint already holds that target.
                if (r_int_pend && div_busy_i) begin
                    w_state_nxt = S_DRAIN;
                end else if (r_int_pend) begin
                    w_redirect      = 1'b1;
                    w_redirect_addr = r_int_vec;
                    w_int_take      = 1'b1;
                end else if (jump_flag_i) begin
                    w_redirect      = 1'b1;
                    w_redirect_addr = jump_addr_i;
                end
                if (w_redirect && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == 2'd0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                end
            end
            S_DRAIN: begin
                if (!div_busy_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_hold = HOLD_NONE;
        if (clint_hold_i || div_busy_i || w_redirect || (r_state != S_RUN)) begin
            w_hold = HOLD_ID;
        end else if (rib_hold_i) begin
            w_hold = HOLD_PC;
        end
    end

    always_comb begin
        hold_flag_o     = HOLD_NONE;
        jump_flag_o     = 1'b0;
        jump_addr_o     = '0;
        stall_timeout_o = 1'b0;
        if (rst) begin
            hold_flag_o     = w_hold;
            jump_flag_o     = w_redirect;
            jump_addr_o     = w_redirect_addr;
            stall_timeout_o = r_to_flag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // A fresh pulse wins over the clear of the interrupt being serviced this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_pend <= 1'b0;
            r_int_vec  <= '0;
        end else if (int_assert_i) begin
            r_int_pend <= 1'b1;
            r_int_vec  <= int_addr_i;
        end else if (w_int_take) begin
            r_int_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (rib_hold_i) begin
                if (r_to_cnt != 16'hFFFF) begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
                if (r_to_cnt == TO_LAST) begin
                    r_to_flag <= 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: two parameterisations driven in parallel, checked every
// cycle against a countdown-style behavioural model plus hand-computed literal points.
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        div_busy_i;
    logic        rib_hold_i;
    logic        clint_hold_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;

    logic [2:0]  hold_a,  hold_b;
    logic        jf_a,    jf_b;
    logic [31:0] ja_a,    ja_b;
    logic        to_a,    to_b;

    always #5 clk = ~clk;

    pipe_hold_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .div_busy_i(div_busy_i), .rib_hold_i(rib_hold_i), .clint_hold_i(clint_hold_i),
        .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
        .hold_flag_o(hold_a), .jump_flag_o(jf_a), .jump_addr_o(ja_a), .stall_timeout_o(to_a)
    );

    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .div_busy_i(div_busy_i), .rib_hold_i(rib_hold_i), .clint_hold_i(clint_hold_i),
        .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
        .hold_flag_o(hold_b), .jump_flag_o(jf_b), .jump_addr_o(ja_b), .stall_timeout_o(to_b)
    );

    // Model state: remaining post-redirect hold cycles, drain flag, stall run length.
    typedef struct packed {
        logic        pend;
        logic [31:0] vec;
        int unsigned flush_left;
        logic        draining;
        int unsigned run;
        logic        flag;
    } mdl_t;

    mdl_t mA, mB;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic        lh_en, lj_en, lt_en;
    logic [2:0]  lh;
    logic        ljf;
    logic [31:0] lja;
    logic        lto;
    string       lit_tag;

    function automatic void mstep(input mdl_t m, input int unsigned fc, input int unsigned n,
                                  output mdl_t nx, output logic [2:0] h, output logic jf,
                                  output logic [31:0] ja, output logic to);
        logic busy;
        nx   = m;
        jf   = 1'b0;
        ja   = '0;
        to   = m.flag;
        busy = (m.flush_left > 0) || m.draining;
        if (m.flush_left > 0) begin
            nx.flush_left = m.flush_left - 1;
        end else if (m.draining) begin
            if (!div_busy_i) nx.draining = 1'b0;
        end else if (m.pend && div_busy_i) begin
            nx.draining = 1'b1;
        end else if (m.pend) begin
            jf = 1'b1; ja = m.vec; nx.pend = 1'b0; nx.flush_left = fc - 1;
        end else if (jump_flag_i) begin
            jf = 1'b1; ja = jump_addr_i; nx.flush_left = fc - 1;
        end
        if (clint_hold_i || div_busy_i || jf || busy) h = 3'd3;
        else if (rib_hold_i)                          h = 3'd1;
        else                                          h = 3'd0;
        if (int_assert_i) begin
            nx.pend = 1'b1;
            nx.vec  = int_addr_i;
        end
        nx.run = rib_hold_i ? ((m.run < 65535) ? m.run + 1 : m.run) : 0;
        if (nx.run >= n) nx.flag = 1'b1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        mdl_t        nx;
        logic [2:0]  eh;
        logic        ejf, eto;
        logic [31:0] eja;
        if (!rst) begin
            mA = '0;
            mB = '0;
            chk("rst_outs_a", {29'd0, hold_a, jf_a, ja_a, to_a}, 64'd0);
            chk("rst_outs_b", {29'd0, hold_b, jf_b, ja_b, to_b}, 64'd0);
        end else begin
            mstep(mA, 3, 8, nx, eh, ejf, eja, eto);
            mA = nx;
            chk("model_a", {29'd0, hold_a, jf_a, ja_a, to_a}, {29'd0, eh, ejf, eja, eto});
            mstep(mB, 1, 2, nx, eh, ejf, eja, eto);
            mB = nx;
            chk("model_b", {29'd0, hold_b, jf_b, ja_b, to_b}, {29'd0, eh, ejf, eja, eto});
        end
        if (lh_en) chk({lit_tag, "_hold"}, 64'(hold_a), 64'(lh));
        if (lj_en) chk({lit_tag, "_jump"}, {31'd0, jf_a, ja_a}, {31'd0, ljf, lja});
        if (lt_en) chk({lit_tag, "_timeout"}, 64'(to_a), 64'(lto));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lh_en = 1'b0; lj_en = 1'b0; lt_en = 1'b0;
    endtask

    task automatic lit_hold(input string tag, input logic [2:0] h);
        lit_tag = tag; lh_en = 1'b1; lh = h;
    endtask

    task automatic lit_jump(input string tag, input logic f, input logic [31:0] a);
        lit_tag = tag; lj_en = 1'b1; ljf = f; lja = a;
    endtask

    task automatic lit_to(input string tag, input logic t);
        lit_tag = tag; lt_en = 1'b1; lto = t;
    endtask

    initial begin
        rst = 1'b0;
        jump_flag_i = 1'b0; jump_addr_i = '0; div_busy_i = 1'b0; rib_hold_i = 1'b0;
        clint_hold_i = 1'b0; int_assert_i = 1'b0; int_addr_i = '0;
        lh_en = 1'b0; lj_en = 1'b0; lt_en = 1'b0; lh = '0; ljf = 1'b0; lja = '0; lto = 1'b0;
        lit_tag = "";
        lit_hold("in_reset", 3'd0); lit_jump("in_reset", 1'b0, 32'h0);
        tick(); tick();
        rst = 1'b1;
        lit_hold("after_reset", 3'd0); lit_jump("after_reset", 1'b0, 32'h0); lit_to("after_reset", 1'b0);
        tick(); tick(); tick();

        // Jump flush, FLUSH_CYCLES=3
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
        lit_hold("jump_c10", 3'd3); lit_jump("jump_c10", 1'b1, 32'h100);
        tick();
        jump_flag_i = 1'b0; jump_addr_i = 32'h0000_0999;
        lit_hold("jump_c11", 3'd3); lit_jump("jump_c11", 1'b0, 32'h0);
        tick();
        lit_hold("jump_c12", 3'd3);
        tick();
        lit_hold("jump_c13", 3'd0); lit_jump("jump_c13", 1'b0, 32'h0);
        tick();

        // Interrupt during a divide
        for (int c = 0; c < 24; c++) begin
            div_busy_i   = (c >= 5) && (c <= 20);
            int_assert_i = (c == 7);
            int_addr_i   = (c == 7) ? 32'h8000_0004 : 32'h0;
            lit_hold("intdiv", (c >= 5) ? 3'd3 : 3'd0);
            if (c < 22)       lit_jump("intdiv_none", 1'b0, 32'h0);
            else if (c == 22) lit_jump("intdiv_redir", 1'b1, 32'h8000_0004);
            tick();
        end
        div_busy_i = 1'b0; int_assert_i = 1'b0;
        tick(); tick(); tick();

        // Pending interrupt collides with an ex jump
        int_assert_i = 1'b1; int_addr_i = 32'hA5A5_0040;
        tick();
        int_assert_i = 1'b0; jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0200;
        lit_hold("collide", 3'd3); lit_jump("collide", 1'b1, 32'hA5A5_0040);
        tick();
        jump_flag_i = 1'b0;
        tick(); tick(); tick();

        // Hold merge
        rib_hold_i = 1'b1; lit_hold("merge_rib", 3'd1);
        tick();
        clint_hold_i = 1'b1; lit_hold("merge_rib_clint", 3'd3);
        tick();
        clint_hold_i = 1'b0; lit_hold("merge_rib_again", 3'd1);
        tick();
        rib_hold_i = 1'b0; lit_hold("merge_idle", 3'd0);
        tick();

        // Stall timeout, STALL_TIMEOUT=8
        rib_hold_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        rib_hold_i = 1'b0; lit_to("to_7cycles", 1'b0);
        tick();
        rib_hold_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) lit_to("to_8th_cycle", 1'b0);
            tick();
        end
        rib_hold_i = 1'b0; lit_to("to_after_8", 1'b1);
        tick();
        lit_to("to_sticky", 1'b1);
        tick();

        // Reset in FLUSH with an interrupt latched there
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0300;
        tick();
        jump_flag_i = 1'b0; int_assert_i = 1'b1; int_addr_i = 32'hDEAD_0000;
        lit_hold("flush_mid", 3'd3); lit_jump("flush_mid", 1'b0, 32'h0);
        tick();
        int_assert_i = 1'b0; rst = 1'b0;
        lit_hold("flush_rst", 3'd0); lit_jump("flush_rst", 1'b0, 32'h0); lit_to("flush_rst", 1'b0);
        tick();
        rst = 1'b1;
        lit_hold("post_rst0", 3'd0); lit_jump("post_rst0", 1'b0, 32'h0); lit_to("post_rst0", 1'b0);
        tick();
        lit_hold("post_rst1", 3'd0); lit_jump("post_rst1", 1'b0, 32'h0);
        tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) != 0);
            jump_flag_i  = ($urandom_range(0, 3) == 0);
            jump_addr_i  = $urandom;
            if (div_busy_i) div_busy_i = ($urandom_range(0, 5) != 0);
            else            div_busy_i = ($urandom_range(0, 9) == 0);
            if (rib_hold_i) rib_hold_i = ($urandom_range(0, 7) != 0);
            else            rib_hold_i = ($urandom_range(0, 5) == 0);
            clint_hold_i = ($urandom_range(0, 7) == 0);
            int_assert_i = ($urandom_range(0, 15) == 0);
            int_addr_i   = $urandom;
            tick();
        end
        rst = 1'b1;
        jump_flag_i = 1'b0; div_busy_i = 1'b0; rib_hold_i = 1'b0;
        clint_hold_i = 1'b0; int_assert_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
